// File: rtl/cp0_unit.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cp0_unit : MIPS coprocessor-0 with timer, masked MTC0 writes, exception/ERET
//            commit and registered fetch redirect.  Revision: 1.0
// ---------------------------------------------------------------------------
module cp0_unit #(
  parameter int          HW_INT_NUM = 6,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter logic [31:0] PRID_VAL   = 32'h004C0102,
  parameter logic [31:0] CONFIG_VAL = 32'h00008000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [4:0]            raddr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o,
  input  logic [HW_INT_NUM-1:0] hw_int_i,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic                  exc_badv_we_i,
  input  logic [31:0]           exc_badvaddr_i,
  input  logic                  eret_i,
  output logic                  int_pending_o,
  output logic                  timer_int_o,
  output logic                  flush_o,
  output logic [31:0]           target_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  localparam logic [4:0] C_REG_BADV    = 5'd8;
  localparam logic [4:0] C_REG_COUNT   = 5'd9;
  localparam logic [4:0] C_REG_COMPARE = 5'd11;
  localparam logic [4:0] C_REG_STATUS  = 5'd12;
  localparam logic [4:0] C_REG_CAUSE   = 5'd13;
  localparam logic [4:0] C_REG_EPC     = 5'd14;
  localparam logic [4:0] C_REG_PRID    = 5'd15;
  localparam logic [4:0] C_REG_CONFIG  = 5'd16;
  localparam logic [3:0] C_PRESC_LAST  = 4'(COUNT_DIV - 1);

  logic [31:0]           badvaddr;
  logic [31:0]           count;
  logic [31:0]           compare;
  logic [31:0]           epc;
  logic [7:0]            status_im;
  logic                  status_exl;
  logic                  status_ie;
  logic                  cause_bd;
  logic [1:0]            cause_ip_sw;
  logic [4:0]            cause_exc;
  logic [HW_INT_NUM-1:0] hw_q;
  logic [3:0]            presc;
  logic                  timer_int;
  logic                  flush;
  logic [31:0]           target;

  logic                  do_exc;
  logic                  do_eret;
  logic                  do_mtc0;
  logic [5:0]            hw_ext;
  logic [7:0]            cause_ip;

  // Exception beats ERET beats MTC0; losers are dropped completely.
  assign do_exc  = exc_valid_i;
  assign do_eret = ~exc_valid_i & eret_i;
  assign do_mtc0 = ~exc_valid_i & ~eret_i & we_i;

  assign hw_ext   = 6'(hw_q);
  assign cause_ip = {hw_ext[5] | timer_int, hw_ext[4:0], cause_ip_sw};

  assign status_o = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl, status_ie};
  assign cause_o  = {cause_bd, timer_int, 14'd0, cause_ip, 1'b0, cause_exc, 2'b00};
  assign epc_o    = epc;

  assign timer_int_o   = timer_int;
  assign flush_o       = flush;
  assign target_o      = target;
  assign int_pending_o = status_ie & ~status_exl & (|(cause_ip & status_im));

  always_ff @(posedge clk) begin
    if (!rst) begin
      badvaddr    <= 32'd0;
      count       <= 32'd0;
      compare     <= 32'd0;
      epc         <= 32'd0;
      status_im   <= 8'd0;
      status_exl  <= 1'b0;
      status_ie   <= 1'b0;
      cause_bd    <= 1'b0;
      cause_ip_sw <= 2'b00;
      cause_exc   <= 5'd0;
      hw_q        <= '0;
      presc       <= 4'd0;
      timer_int   <= 1'b0;
      flush       <= 1'b0;
      target      <= 32'd0;
    end else begin
      hw_q <= hw_int_i;

      if (do_mtc0 && waddr_i == C_REG_COUNT) begin
        count <= wdata_i;
        presc <= 4'd0;
      end else if (presc == C_PRESC_LAST) begin
        count <= count + 32'd1;
        presc <= 4'd0;
      end else begin
        presc <= presc + 4'd1;
      end

      if (do_mtc0 && waddr_i == C_REG_COMPARE) begin
        compare   <= wdata_i;
        timer_int <= 1'b0;
      end else if (count == compare && compare != 32'd0) begin
        timer_int <= 1'b1;
      end

      if (do_exc) begin
        // A nested exception keeps the original return point.
        if (!status_exl) begin
          epc      <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
          cause_bd <= exc_bd_i;
        end
        status_exl <= 1'b1;
        cause_exc  <= exc_code_i;
        if (exc_badv_we_i) begin
          badvaddr <= exc_badvaddr_i;
        end
      end else if (do_eret) begin
        status_exl <= 1'b0;
      end else if (do_mtc0) begin
        if (waddr_i == C_REG_STATUS) begin
          status_im  <= wdata_i[15:8];
          status_exl <= wdata_i[1];
          status_ie  <= wdata_i[0];
        end
        if (waddr_i == C_REG_CAUSE) begin
          cause_ip_sw <= wdata_i[9:8];
        end
        if (waddr_i == C_REG_EPC) begin
          epc <= wdata_i;
        end
      end

      flush <= do_exc | do_eret;
      if (do_exc) begin
        target <= EXC_VECTOR;
      end else if (do_eret) begin
        target <= epc;
      end
    end
  end

  always_comb begin
    rdata_o = 32'd0;
    if (rst) begin
      case (raddr_i)
        C_REG_BADV:    rdata_o = badvaddr;
        C_REG_COUNT:   rdata_o = count;
        C_REG_COMPARE: rdata_o = compare;
        C_REG_STATUS:  rdata_o = status_o;
        C_REG_CAUSE:   rdata_o = cause_o;
        C_REG_EPC:     rdata_o = epc;
        C_REG_PRID:    rdata_o = PRID_VAL;
        C_REG_CONFIG:  rdata_o = CONFIG_VAL;
        default:       rdata_o = 32'd0;
      endcase
    end
  end

endmodule
`default_nettype wire
